vga_text_sched: RTL and testbench

- Sequences the 16-symbol text line buffer that feeds the VGA output character box.
- Shares the buffer between two requesters: CPU output port (port 0) and keyboard echo path (port 1), using a fair round-robin arbiter with a req/ack handshake.
- Interprets control codes (backspace, clear, newline) and scrolls the line left when it is full.
- Sits in clk_50 domain ahead of vga_lcd; drives its packed characters vector directly.

---
 rtl/vga_text_pkg.sv | 20 ++
 rtl/vga_text_rr2.sv | 32 +++
 rtl/vga_text_sched.sv | 140 ++++++++++++++
 tb/tb_vga_text_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and state encoding for the VGA text line scheduler.
package vga_text_pkg;

  localparam int CW = 7;

  localparam logic [6:0] CC_BS        = 7'h08;
  localparam logic [6:0] CC_LF        = 7'h0A;
  localparam logic [6:0] CC_FF        = 7'h0C;
  localparam logic [6:0] CC_PRINT_MIN = 7'h20;

  localparam logic [6:0] CURSOR_GLYPH = 7'h5F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_t;

endpackage

// File: rtl/vga_text_rr2.sv
// Two-requester round-robin grant: combinational one-hot grant plus the
// last-served pointer, which starts at port 1 so port 0 wins the first tie.
module vga_text_rr2 (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant,
  output logic       last_served
);

  logic last_served_reg;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      last_served_reg <= 1'b1;
    end else if (update) begin
      last_served_reg <= served;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_served_reg ? 2'b01 : 2'b10;
    end
  end

  assign last_served = last_served_reg;

endmodule

// File: rtl/vga_text_sched.sv
// Text line buffer scheduler: arbitrates two code sources, applies control
// codes and scrolling. Optional blinking cursor under VGA_TEXT_CURSOR_EN.
module vga_text_sched
  import vga_text_pkg::*;
#(
  parameter int SYMBOLS = 16,
  parameter int CW = vga_text_pkg::CW
`ifdef VGA_TEXT_CURSOR_EN
  ,
  parameter int BLINK_CYCLES = 12500000
`endif
) (
  input  logic                      clk_50,
  input  logic                      reset_n,
  input  logic [1:0]                req,
  input  logic [CW-1:0]             code0,
  input  logic [CW-1:0]             code1,
  output logic [1:0]                ack,
  output logic [SYMBOLS*CW-1:0]     characters,
  output logic [$clog2(SYMBOLS):0]  free_x,
  output logic                      busy
);

  localparam int AW = $clog2(SYMBOLS);
  localparam int XW = AW + 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   code_reg;
  logic            port_reg;
  logic [CW-1:0]   sym_reg [SYMBOLS];
  logic [XW-1:0]   free_x_reg;
  logic [XW-1:0]   fx_dec;
  logic [1:0]      grant;
  logic            last_served;

  vga_text_rr2 u_rr (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .req         (req),
    .update      (state_reg == ACK),
    .served      (port_reg),
    .grant       (grant),
    .last_served (last_served)
  );

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack        = 2'b00;
    case (state_reg)
      IDLE: if (|req) state_next = EXEC;
      EXEC: state_next = ACK;
      ACK: begin
        ack        = port_reg ? 2'b10 : 2'b01;
        state_next = REL;
      end
      REL: if (!req[port_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Code and port are captured at grant; later input changes are ignored.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      code_reg <= '0;
      port_reg <= 1'b0;
    end else if (state_reg == IDLE && (|req)) begin
      port_reg <= grant[1];
      code_reg <= grant[1] ? code1 : code0;
    end
  end

  assign fx_dec = free_x_reg - XW'(1);

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      for (int i = 0; i < SYMBOLS; i++) sym_reg[i] <= '0;
      free_x_reg <= '0;
    end else if (state_reg == EXEC) begin
      if (code_reg == CW'(CC_BS)) begin
        if (free_x_reg != '0) begin
          free_x_reg              <= fx_dec;
          sym_reg[fx_dec[AW-1:0]] <= '0;
        end
      end else if (code_reg == CW'(CC_FF) || code_reg == CW'(CC_LF)) begin
        for (int i = 0; i < SYMBOLS; i++) sym_reg[i] <= '0;
        free_x_reg <= '0;
      end else if (code_reg < CW'(CC_PRINT_MIN)) begin
        free_x_reg <= free_x_reg;
      end else if (free_x_reg < XW'(SYMBOLS)) begin
        sym_reg[free_x_reg[AW-1:0]] <= code_reg;
        free_x_reg                  <= free_x_reg + XW'(1);
      end else begin
        // Full line: scroll left and append at the last column.
        for (int i = 0; i < SYMBOLS - 1; i++) sym_reg[i] <= sym_reg[i+1];
        sym_reg[SYMBOLS-1] <= code_reg;
      end
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt_reg;
  logic          cursor_on_reg;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      cursor_on_reg <= 1'b0;
    end else if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_reg <= '0;
      cursor_on_reg <= ~cursor_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  // The glyph overlays only the output; a column index match implies free_x < SYMBOLS.
  for (genvar gi = 0; gi < SYMBOLS; gi++) begin : g_out
    assign characters[gi*CW +: CW] =
      (cursor_on_reg && free_x_reg == XW'(gi)) ? CW'(CURSOR_GLYPH) : sym_reg[gi];
  end
`else
  for (genvar gi = 0; gi < SYMBOLS; gi++) begin : g_out
    assign characters[gi*CW +: CW] = sym_reg[gi];
  end
`endif

  assign free_x = free_x_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_vga_text_sched.sv
// Table-driven bench with a scoreboard for the VGA text line scheduler.
module tb_vga_text_sched;

  localparam int SYM = 16;
  localparam int CWB = 7;

  logic               clk_50 = 1'b0;
  logic               reset_n;
  logic [1:0]         req;
  logic [CWB-1:0]     code0, code1;
  logic [1:0]         ack;
  logic [SYM*CWB-1:0] characters;
  logic [4:0]         free_x;
  logic               busy;

  always #10 clk_50 = ~clk_50;

  vga_text_sched #(.SYMBOLS(SYM), .CW(CWB)) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .req        (req),
    .code0      (code0),
    .code1      (code1),
    .ack        (ack),
    .characters (characters),
    .free_x     (free_x),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]         ack;
    logic [SYM*CWB-1:0] chars;
    int                 fx;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic           port;
    logic [CWB-1:0] code;
    int             exp_fx;
    int             chk_idx;
    logic [CWB-1:0] chk_val;
  } vec_t;
  vec_t vt[10];

  logic [CWB-1:0] m_sym [SYM];
  int             m_fx;
  logic           m_last;

  task automatic check(input string nm, input logic [SYM*CWB-1:0] act,
                       input logic [SYM*CWB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [SYM*CWB-1:0] m_pack();
    logic [SYM*CWB-1:0] r;
    for (int i = 0; i < SYM; i++) r[i*CWB +: CWB] = m_sym[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < SYM; i++) m_sym[i] = '0;
    m_fx   = 0;
    m_last = 1'b1;
  endtask

  task automatic m_apply(input logic [CWB-1:0] c);
    if (c == 7'h08) begin
      if (m_fx > 0) begin
        m_fx--;
        m_sym[m_fx] = '0;
      end
    end else if (c == 7'h0C || c == 7'h0A) begin
      for (int i = 0; i < SYM; i++) m_sym[i] = '0;
      m_fx = 0;
    end else if (c < 7'h20) begin
      m_fx = m_fx;
    end else if (m_fx < SYM) begin
      m_sym[m_fx] = c;
      m_fx++;
    end else begin
      for (int i = 0; i < SYM - 1; i++) m_sym[i] = m_sym[i+1];
      m_sym[SYM-1] = c;
    end
  endtask

  task automatic push_exp(input logic port, input logic [CWB-1:0] c);
    exp_t e;
    m_apply(c);
    e.ack   = port ? 2'b10 : 2'b01;
    e.chars = m_pack();
    e.fx    = m_fx;
    sb.push_back(e);
    m_last = port;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk_50); #1;
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk_50); #1;
      cyc++;
    end while (ack === 2'b00 && cyc < 20);
  endtask

  task automatic send(input logic port, input logic [CWB-1:0] c);
    int cyc;
    wait_idle();
    if (port) code1 = c; else code0 = c;
    push_exp(port, c);
    req[port] = 1'b1;
    wait_ack(cyc);
    check("ack_latency", cyc, 2);
    req[port] = 1'b0;
    @(posedge clk_50); #1;
    check("ack_one_cycle", ack, 0);
    $display("send port=%0d code=%h free_x=%0d ack_cyc=%0d", port, c, free_x, cyc);
  endtask

  // Scoreboard: every acknowledge retires the oldest expected result.
  always begin
    exp_t e;
    @(posedge clk_50); #1;
    if (ack !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", ack, 0);
      end else begin
        e = sb.pop_front();
        check("sb_ack", ack, e.ack);
        check("sb_chars", characters, e.chars);
        check("sb_free_x", free_x, e.fx);
      end
    end
  end

  initial begin
    int cyc;
    int cnt0, cnt1;
    logic p;

    vt[0] = '{1'b0, 7'h41, 1, 0, 7'h41};
    vt[1] = '{1'b0, 7'h42, 2, 1, 7'h42};
    vt[2] = '{1'b1, 7'h08, 1, 1, 7'h00};
    vt[3] = '{1'b1, 7'h43, 2, 1, 7'h43};
    vt[4] = '{1'b0, 7'h00, 2, 1, 7'h43};
    vt[5] = '{1'b0, 7'h0C, 0, 0, 7'h00};
    vt[6] = '{1'b0, 7'h08, 0, 0, 7'h00};
    vt[7] = '{1'b1, 7'h5A, 1, 0, 7'h5A};
    vt[8] = '{1'b0, 7'h0A, 0, 0, 7'h00};
    vt[9] = '{1'b0, 7'h1F, 0, 0, 7'h00};

    reset_n = 1'b0;
    req     = 2'b00;
    code0   = '0;
    code1   = '0;
    m_reset();
    repeat (2) @(posedge clk_50);
    #1;
    check("rst_chars", characters, 0);
    check("rst_free_x", free_x, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vt[i].port, vt[i].code);
      check("vec_free_x", free_x, vt[i].exp_fx);
      check("vec_sym", characters[vt[i].chk_idx*CWB +: CWB], vt[i].chk_val);
    end

    for (int c = 8'h41; c <= 8'h51; c++) send(1'b0, CWB'(c));
    check("full_free_x", free_x, 16);
    check("scroll_sym0", characters[0 +: CWB], 7'h42);
    check("scroll_sym15", characters[15*CWB +: CWB], 7'h51);

    // Both ports keep requesting; each served port releases then reasserts.
    send(1'b0, 7'h0C);
    wait_idle();
    code0 = 7'h31;
    code1 = 7'h32;
    cnt0 = 0;
    cnt1 = 0;
    p = ~m_last;
    push_exp(p, p ? 7'h32 : 7'h31);
    req = 2'b11;
    for (int r = 0; r < 10; r++) begin
      wait_ack(cyc);
      check("arb_grant", ack, p ? 2'b10 : 2'b01);
      $display("arb round=%0d ack=%b expect_port=%0d", r, ack, p);
      if (ack == 2'b01) cnt0++;
      if (ack == 2'b10) cnt1++;
      req[p] = 1'b0;
      wait_idle();
      p = ~p;
      if (r < 9) push_exp(p, p ? 7'h32 : 7'h31);
      req[~p] = 1'b1;
    end
    req = 2'b00;
    check("arb_cnt0", cnt0, 5);
    check("arb_cnt1", cnt1, 5);
    check("arb_free_x", free_x, 10);

    // Reset while the grant is executing aborts without an acknowledge.
    wait_idle();
    code0 = 7'h41;
    req[0] = 1'b1;
    @(posedge clk_50); #1;
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk_50); #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_chars", characters, 0);
    check("mid_rst_free_x", free_x, 0);
    check("mid_rst_busy", busy, 0);
    req = 2'b00;
    @(posedge clk_50); #1;
    check("mid_rst_ack2", ack, 0);
    reset_n = 1'b1;
    m_reset();
    $display("reset during exec: free_x=%0d busy=%0d", free_x, busy);

    // First tie after reset goes to port 0, then port 1 is served.
    code0 = 7'h33;
    code1 = 7'h34;
    push_exp(1'b0, 7'h33);
    req = 2'b11;
    wait_ack(cyc);
    check("tie_first", ack, 2'b01);
    push_exp(1'b1, 7'h34);
    req[0] = 1'b0;
    wait_ack(cyc);
    check("tie_second", ack, 2'b10);
    req[1] = 1'b0;
    $display("tie after reset: free_x=%0d", free_x);

    repeat (4) @(posedge clk_50);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
